// File: rtl/addsub_chunked.sv
// Multi-cycle WIDTH-bit adder/subtractor: sums CHUNK bits per clock with a registered carry,
// and returns the result over a four-phase REQ/ACK handshake.
module addsub_chunked #(
    parameter int WIDTH = 24,
    parameter int CHUNK = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    input  logic             SUB,
    input  logic             REQ,
    output logic [WIDTH-1:0] Z,
    output logic             COUT,
    output logic             OVF,
    output logic             ACK,
    output logic             BUSY
);

    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int LASTW  = WIDTH - (NCHUNK - 1) * CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    // ACK is the DONE bit of the state register itself, so it is glitch-free.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, shadow, shadow_next;
    logic [IW-1:0]    idx;
    logic             carry_reg, carry_next, last_chunk, ovf_next;
    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic [CHUNK:0]   chunk_sum;
    int               base;

    always_comb begin
        base       = int'(idx) * CHUNK;
        last_chunk = (idx == IW'(NCHUNK - 1));
        a_chunk    = CHUNK'(a_reg >> base);
        b_chunk    = CHUNK'(b_reg >> base);
        chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_reg};
        // The last chunk may be narrower; its zero padding leaves the true carry at bit LASTW.
        carry_next  = last_chunk ? chunk_sum[LASTW] : chunk_sum[CHUNK];
        shadow_next = (shadow & ~(WIDTH'({CHUNK{1'b1}}) << base))
                    | (WIDTH'(chunk_sum[CHUNK-1:0]) << base);
        ovf_next    = (a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ shadow_next[WIDTH-1]) ^ carry_next;

        state_next = state;
        case (state)
            IDLE:    if (REQ)        state_next = CALC;
            CALC:    if (last_chunk) state_next = DONE;
            DONE:    if (!REQ)       state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    // NOTE: every register lives in this one clocked block and uses <=, so all of them
    // sample the same pre-edge values; the chunk arithmetic above is purely combinational.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            shadow    <= '0;
            idx       <= '0;
            carry_reg <= 1'b0;
            Z         <= '0;
            COUT      <= 1'b0;
            OVF       <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (REQ) begin
                    a_reg     <= A;
                    b_reg     <= SUB ? ~B : B;
                    carry_reg <= SUB ? 1'b1 : CIN;
                    idx       <= '0;
                end
                CALC: begin
                    shadow    <= shadow_next;
                    carry_reg <= carry_next;
                    idx       <= idx + IW'(1);
                    if (last_chunk) begin
                        Z    <= shadow_next;
                        COUT <= carry_next;
                        OVF  <= ovf_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ACK  = state[1];
    assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_addsub_chunked.sv
// Directed bench for addsub_chunked: a 24/8 instance for the arithmetic and handshake checks,
// and a 20/8 instance for the reset-mid-operation and narrow-last-chunk checks.
module tb_addsub_chunked;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        rst1, cin1, sub1, req1, cout1, ovf1, ack1, busy1;
    logic [23:0] a1, b1, z1;
    logic        rst2, cin2, sub2, req2, cout2, ovf2, ack2, busy2;
    logic [19:0] a2, b2, z2;

    addsub_chunked #(.WIDTH(24), .CHUNK(8)) u_w24 (
        .CLK(CLK), .RST(rst1), .A(a1), .B(b1), .CIN(cin1), .SUB(sub1), .REQ(req1),
        .Z(z1), .COUT(cout1), .OVF(ovf1), .ACK(ack1), .BUSY(busy1)
    );

    addsub_chunked #(.WIDTH(20), .CHUNK(8)) u_w20 (
        .CLK(CLK), .RST(rst2), .A(a2), .B(b2), .CIN(cin2), .SUB(sub2), .REQ(req2),
        .Z(z2), .COUT(cout2), .OVF(ovf2), .ACK(ack2), .BUSY(busy2)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Counts edges after the capture edge until ACK rises; a missing ACK shows up as a bad latency.
    task automatic wait_ack(input bit w20, input string tag, input int exp_lat);
        int  n    = 0;
        bit  seen = 1'b0;
        while (!seen && n < 12) begin
            tick();
            n++;
            seen = w20 ? ack2 : ack1;
        end
        check({tag, "_lat"}, n, exp_lat);
    endtask

    task automatic op1(input string tag, input logic [23:0] a, input logic [23:0] b,
                       input logic cin, input logic sub,
                       input logic [23:0] ez, input logic ecout, input logic eovf);
        a1 = a; b1 = b; cin1 = cin; sub1 = sub; req1 = 1'b1;
        tick();
        check({tag, "_busy"}, busy1, 1);
        wait_ack(1'b0, tag, 3);
        check({tag, "_z"}, z1, ez);
        check({tag, "_cout"}, cout1, ecout);
        check({tag, "_ovf"}, ovf1, eovf);
        req1 = 1'b0;
        tick();
        check({tag, "_ackdrop"}, ack1, 0);
        check({tag, "_idle"}, busy1, 0);
    endtask

    initial begin
        rst1 = 1'b1; req1 = 1'b1; a1 = 24'hFFFFFF; b1 = 24'hFFFFFF; cin1 = 1'b0; sub1 = 1'b0;
        rst2 = 1'b1; req2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; sub2 = 1'b0;

        // Reset holds everything at zero even with REQ high.
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_z", z1, 0);
            check("rst_cout", cout1, 0);
            check("rst_ovf", ovf1, 0);
            check("rst_ack", ack1, 0);
            check("rst_busy", busy1, 0);
        end

        // First non-reset edge captures; full carry chain across all chunks.
        a1 = 24'hFFFFFF; b1 = 24'h000001; rst1 = 1'b0;
        tick();
        check("carry_busy", busy1, 1);
        check("carry_ack0", ack1, 0);
        wait_ack(1'b0, "carry", 3);
        check("carry_z", z1, 24'h000000);
        check("carry_cout", cout1, 1);
        check("carry_ovf", ovf1, 0);
        req1 = 1'b0;
        tick();
        check("carry_ackdrop", ack1, 0);

        op1("cin",   24'hFFFFFF, 24'h000000, 1'b1, 1'b0, 24'h000000, 1'b1, 1'b0);
        op1("sub_a", 24'h000005, 24'h000007, 1'b0, 1'b1, 24'hFFFFFE, 1'b0, 1'b0);
        op1("sub_b", 24'h7FFFFF, 24'hFFFFFF, 1'b1, 1'b1, 24'h800000, 1'b0, 1'b1);
        op1("sub_c", 24'h800000, 24'h000001, 1'b0, 1'b1, 24'h7FFFFF, 1'b1, 1'b1);

        // REQ held past ACK: no second capture, result stable.
        a1 = 24'h000100; b1 = 24'h000200; cin1 = 1'b0; sub1 = 1'b0; req1 = 1'b1;
        tick();
        wait_ack(1'b0, "hold", 3);
        check("hold_z", z1, 24'h000300);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_ack", ack1, 1);
            check("hold_zstable", z1, 24'h000300);
            check("hold_busy", busy1, 1);
        end
        req1 = 1'b0;
        tick();
        check("hold_ackdrop", ack1, 0);
        check("hold_busydrop", busy1, 0);

        // Previous result holds through the next computation until its ACK.
        a1 = 24'h000001; b1 = 24'h000002; req1 = 1'b1;
        tick();
        check("rerz_cap", z1, 24'h000300);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rerz_hold", z1, 24'h000300);
            check("rerz_noack", ack1, 0);
        end
        tick();
        check("rerz_ack", ack1, 1);
        check("rerz_z", z1, 24'h000003);
        req1 = 1'b0;
        tick();

        // Inputs change and REQ drops right after capture: captured operands win, ACK pulses once.
        a1 = 24'h000010; b1 = 24'h000020; sub1 = 1'b0; cin1 = 1'b0; req1 = 1'b1;
        tick();
        a1 = 24'hFFFFFF; b1 = 24'hFFFFFF; sub1 = 1'b1; cin1 = 1'b1; req1 = 1'b0;
        wait_ack(1'b0, "midchg", 3);
        check("midchg_z", z1, 24'h000030);
        check("midchg_cout", cout1, 0);
        check("midchg_ovf", ovf1, 0);
        tick();
        check("midchg_pulse", ack1, 0);
        check("midchg_idle", busy1, 0);
        tick();
        check("midchg_stayidle", busy1, 0);

        // 20-bit instance: a normal op, then reset after chunk 1 discards the next op.
        rst2 = 1'b0; a2 = 20'h00001; b2 = 20'h00002; req2 = 1'b1;
        tick();
        wait_ack(1'b1, "w20_pre", 3);
        check("w20_pre_z", z2, 20'h00003);
        req2 = 1'b0;
        tick();
        a2 = 20'h12345; b2 = 20'h00001; req2 = 1'b1;
        tick();
        tick();
        tick();
        rst2 = 1'b1;
        tick();
        check("w20_rst_z", z2, 0);
        check("w20_rst_cout", cout2, 0);
        check("w20_rst_ovf", ovf2, 0);
        check("w20_rst_ack", ack2, 0);
        check("w20_rst_busy", busy2, 0);
        rst2 = 1'b0; req2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("w20_noack", ack2, 0);
        end

        // Narrow last chunk: carry out of bit 19 and signed overflow.
        a2 = 20'h80000; b2 = 20'h80000; req2 = 1'b1;
        tick();
        wait_ack(1'b1, "w20", 3);
        check("w20_z", z2, 20'h00000);
        check("w20_cout", cout2, 1);
        check("w20_ovf", ovf2, 1);
        req2 = 1'b0;
        tick();
        check("w20_ackdrop", ack2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
